// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: four-way round-robin arbiter for a FIFO write port with optional burst lock (FIFO_ARB_BURST_LOCK_EN)
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [3:0]              i_req_valid,
  input  logic [4*DATA_WIDTH-1:0] i_req_data,
  output logic [3:0]              o_req_ready,
  input  logic                    i_fifo_full,
  output logic                    o_fifo_wr,
  output logic [DATA_WIDTH-1:0]   o_fifo_w_data,
  output logic [1:0]              o_grant_id,
  output logic                    o_busy
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
`ifdef FIFO_ARB_BURST_LOCK_EN
  logic [7:0] r_cnt;
`endif
  logic       w_found;
  logic [1:0] w_sel;
  logic [1:0] w_gid;
  logic [3:0] w_ready;
  logic       w_go;
  // first valid requester scanning from r_ptr upward; lowest offset wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (i_req_valid[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_sel   = r_ptr + 2'(k);
      end
    end
  end
  assign w_gid   = (r_state == LOCK) ? (i_req_valid[r_owner] ? r_owner : 2'd0)
                                     : (w_found ? w_sel : 2'd0);
  assign w_ready = i_fifo_full ? 4'b0
                 : (r_state == LOCK) ? (4'b1 << r_owner)
                 : (w_found ? (4'b1 << w_sel) : 4'b0);
  assign w_go          = |(w_ready & i_req_valid);
  assign o_req_ready   = i_rst_n ? w_ready : 4'b0;
  assign o_fifo_wr     = i_rst_n & w_go;
  assign o_grant_id    = i_rst_n ? w_gid : 2'd0;
  assign o_fifo_w_data = o_fifo_wr ? i_req_data[w_gid*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_busy        = (r_state == LOCK);
  // arbitration state: grant on accept, hold owner for a burst, release to the next requester
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
`ifdef FIFO_ARB_BURST_LOCK_EN
      r_cnt   <= 8'd0;
`endif
    end else if (r_state == IDLE) begin
      if (w_go) begin
        r_owner <= w_sel;
`ifdef FIFO_ARB_BURST_LOCK_EN
        r_cnt   <= 8'd1;
        if (BURST_LEN == 1) r_ptr <= w_sel + 2'd1;
        else r_state <= LOCK;
`else
        r_ptr   <= w_sel + 2'd1;
`endif
      end
    end
`ifdef FIFO_ARB_BURST_LOCK_EN
    else begin
      if (w_go) r_cnt <= r_cnt + 8'd1;
      if (!i_req_valid[r_owner] || (w_go && (r_cnt + 8'd1 == 8'(BURST_LEN)))) begin
        r_state <= IDLE;
        r_ptr   <= r_owner + 2'd1;
      end
    end
`endif
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Four-requester round-robin write arbiter that shares the single write port of the synchronous FIFO (`fifo_ram_syn`) between independent producers. Each producer gets a valid/ready handshake. The arbiter drives the FIFO `wr`/`w_data` inputs and observes `full`. An optional burst lock holds the grant on one producer for up to `BURST_LEN` consecutive words, so short packets stay contiguous in the FIFO.

## Interface
- `DATA_WIDTH`, 8, width of one data word; must match the FIFO.
- `BURST_LEN`, 4, maximum words per grant when burst lock is compiled in; legal range 1..255.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  4  per-requester word-valid; bit i belongs to requester i.
- `req_data`  in  4*DATA_WIDTH  requester i's word is `req_data[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  4  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- `fifo_full`  in  1  connected to the FIFO `full` output.
- `fifo_wr`  out  1  connected to the FIFO `wr` input.
- `fifo_w_data`  out  DATA_WIDTH  connected to the FIFO `w_data` input.
- `grant_id`  out  2  index of the requester selected this cycle; 0 when none is selected.
- `busy`  out  1  high while in state LOCK.

## Operation
- **Transfer rule.** A word transfers when `req_valid[i] & req_ready[i]`. In that cycle `fifo_wr` = 1 and `fifo_w_data` = requester i's word.
  - `req_ready`, `fifo_wr` and `fifo_w_data` are combinational from registered state, `req_valid` and `fifo_full`.
  - `fifo_wr` is never high while `fifo_full` = 1, so the FIFO is never overflowed.
- **Producer obligations.** A producer holds its data stable while valid is high and ready is low. It may drop valid at any time.
- **Registered state:**
  - `state`: IDLE or LOCK.
  - `ptr`: 2 bits, round-robin start point.
  - `owner`: 2 bits.
  - `cnt`: 8 bits.
- **IDLE.**
  - Select the first `i` with `req_valid[i]` = 1, scanning `ptr`, `ptr+1`, … modulo 4.
  - If a requester is selected and `fifo_full` = 0: accept the word, set `owner` = i, set `cnt` = 1.
    - If `BURST_LEN` = 1, stay in IDLE and set `ptr` = i+1.
    - Otherwise go to LOCK.
  - If `fifo_full` = 1: `grant_id` still shows the selected requester, but `req_ready` = 0 and no state changes.
- **LOCK.**
  - Only `owner` may be ready: `req_ready[owner]` = `~fifo_full`, and all other bits are 0.
  - On accept: `cnt` increments. If the new `cnt` equals `BURST_LEN`, go to IDLE and set `ptr` = owner+1.
  - If `req_valid[owner]` = 0: no transfer this cycle; go to IDLE and set `ptr` = owner+1.
  - While `fifo_full` = 1 with owner valid: stall, with `cnt` and `owner` unchanged.
- **Wrap-around.** `ptr` and `owner` arithmetic is modulo 4, so 3+1 = 0.
- **Reset.** While `reset` = 0, all combinational outputs are forced to 0. State returns to IDLE with `ptr`, `owner` and `cnt` = 0. Deasserting reset mid-burst never resumes the old burst.

## Timing
- Zero-cycle accept latency: a word is written to the FIFO in the same cycle its handshake completes.
- One idle cycle on early release: when the owner drops valid in LOCK, nothing is granted that cycle. Arbitration resumes next cycle.
- A full burst ends with no bubble; IDLE arbitration happens in the cycle right after the last word.
- Maximum throughput is one word per cycle while `fifo_full` = 0.
- Reset values:
  - `req_ready` = 0, `fifo_wr` = 0, `fifo_w_data` = 0, `grant_id` = 0, `busy` = 0.
  - `state` = IDLE, `ptr` = 0, `owner` = 0, `cnt` = 0.

## Configuration
- Macro `FIFO_ARB_BURST_LOCK_EN`.
  - **Defined:** LOCK state and `cnt` are built, and `BURST_LEN` applies as described above.
  - **Undefined:** the arbiter never leaves IDLE. Every accepted word advances `ptr` to owner+1, giving pure per-word round-robin. `busy` is tied to 0, `cnt` is not built, and `BURST_LEN` is ignored.

## Test plan
- Reset with all four valids high → all outputs 0 while reset is low. After release, the first write carries requester 0's data and `grant_id` = 0.
- Burst lock on, `BURST_LEN` = 4, requesters 0 and 2 continuously valid → write order is r0 ×4, r2 ×4, r0 ×4, …, with no idle cycles.
- Burst lock on, requester 1 drops valid after 2 words → one idle cycle with `busy` = 1 → `busy` = 0, and the next grant goes to the next valid requester after 1 (2, then 3, then 0).
- Raise `fifo_full` mid-burst for 3 cycles → `fifo_wr` = 0 and `req_ready` = 0 for those 3 cycles. The burst resumes with `cnt` unchanged, the total is still 4 words, and the FIFO receives no extra or lost words.
- Burst lock off, all four valid → grants rotate 0, 1, 2, 3, 0 one word per cycle; ptr wrap 3 → 0 verified.
- Reset asserted mid-LOCK (owner = 3, `cnt` = 2) → outputs are 0 immediately. After release, grant starts from requester 0 with no resumed burst.
